// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage M-extension unit.
// Op encodings, FSM states and the iterative step count.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV*/REM* return 0.
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_o
);

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        neg_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] opd_q;

    logic        is_div;
    logic        a_sgn;
    logic        b_sgn;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        start_neg;
    logic        special;
    logic [31:0] special_res;

    assign is_div = funct3_i[2];

    always_comb begin
        a_sgn = (funct3_i != F3_MULHU) && (funct3_i != F3_DIVU)
             && (funct3_i != F3_REMU);
        b_sgn = (funct3_i == F3_MUL) || (funct3_i == F3_MULH)
             || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    end

    assign neg_a = a_sgn & op_a_i[31];
    assign neg_b = b_sgn & op_b_i[31];
    assign mag_a = neg_a ? -op_a_i : op_a_i;
    assign mag_b = neg_b ? -op_b_i : op_b_i;

`ifdef MULDIV_DIV_EN
    logic div0;
    logic ovf;

    assign div0 = is_div && (op_b_i == 32'h0);
    assign ovf  = is_div && b_sgn && (op_a_i == 32'h8000_0000)
               && (op_b_i == 32'hFFFF_FFFF);
    assign special = div0 | ovf;

    // REM takes the dividend's sign; quotients and products the xor
    assign start_neg = (is_div && funct3_i[1]) ? neg_a : (neg_a ^ neg_b);

    always_comb begin
        special_res = 32'h0;
        unique case (1'b1)
            div0 && funct3_i[1]:  special_res = op_a_i;
            div0 && !funct3_i[1]: special_res = 32'hFFFF_FFFF;
            !div0 && funct3_i[1]: special_res = 32'h0;
            default:              special_res = 32'h8000_0000;
        endcase
    end
`else
    assign special     = is_div;
    assign special_res = 32'h0;
    assign start_neg   = neg_a ^ neg_b;
`endif

    logic [32:0] mul_sum;
    logic [31:0] hi_nxt;
    logic [31:0] lo_nxt;
    logic [63:0] prod;
    logic [63:0] prod_s;
    logic [31:0] res_fin;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : 33'd0);

`ifdef MULDIV_DIV_EN
    logic [32:0] r_sh;
    logic [33:0] diff;

    assign r_sh = {hi_q, lo_q[31]};
    assign diff = {1'b0, r_sh} - {2'b00, opd_q};

    always_comb begin
        if (f3_q[2]) begin
            hi_nxt = diff[33] ? r_sh[31:0] : diff[31:0];
            lo_nxt = {lo_q[30:0], ~diff[33]};
        end else begin
            hi_nxt = mul_sum[32:1];
            lo_nxt = {mul_sum[0], lo_q[31:1]};
        end
    end
`else
    assign hi_nxt = mul_sum[32:1];
    assign lo_nxt = {mul_sum[0], lo_q[31:1]};
`endif

    assign prod   = {hi_nxt, lo_nxt};
    assign prod_s = neg_q ? -prod : prod;

    always_comb begin
        res_fin = 32'h0;
        unique case (1'b1)
`ifdef MULDIV_DIV_EN
            f3_q[2] && f3_q[1]:  res_fin = neg_q ? -hi_nxt : hi_nxt;
            f3_q[2] && !f3_q[1]: res_fin = neg_q ? -lo_nxt : lo_nxt;
`endif
            f3_q == F3_MUL:      res_fin = prod_s[31:0];
            default:             res_fin = prod_s[63:32];
        endcase
    end

    assign stall_o = ((state_q == S_IDLE) & start_i & ~kill_i)
                   | (state_q == S_CALC);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            f3_q     <= 3'd0;
            rd_q     <= 5'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            opd_q    <= 32'h0;
            done_o   <= 1'b0;
            result_o <= 32'h0;
            rd_o     <= 5'd0;
        end else begin
            done_o <= 1'b0;
            if (kill_i) begin
                state_q <= S_IDLE;
                cnt_q   <= 6'd0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            f3_q  <= funct3_i;
                            rd_q  <= rd_i;
                            neg_q <= start_neg;
                            cnt_q <= 6'd0;
                            if (special) begin
                                state_q  <= S_FIX;
                                done_o   <= 1'b1;
                                result_o <= special_res;
                                rd_o     <= rd_i;
                            end else begin
                                state_q <= S_CALC;
                                hi_q    <= 32'h0;
                                opd_q   <= is_div ? mag_b : mag_a;
                                lo_q    <= is_div ? mag_a : mag_b;
                            end
                        end
                    end
                    S_CALC: begin
                        hi_q <= hi_nxt;
                        lo_q <= lo_nxt;
                        if (cnt_q == 6'(ITER - 1)) begin
                            state_q  <= S_FIX;
                            cnt_q    <= 6'd0;
                            done_o   <= 1'b1;
                            result_o <= res_fin;
                            rd_o     <= rd_q;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                    S_FIX:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed scoreboard bench for ex_muldiv_unit.
// Divide expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        kill_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    ex_muldiv_unit dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .kill_i   (kill_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .rd_i     (rd_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] dv(input logic [31:0] x);
`ifdef MULDIV_DIV_EN
        return x;
`else
        return 32'h0;
`endif
    endfunction

    function automatic int dl(input int n);
`ifdef MULDIV_DIV_EN
        return n;
`else
        return 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat);
        exp_t e;
        int   lat;
        int   stl;
        e.res = exp;
        e.rd  = rd;
        e.lat = exp_lat;
        sb.push_back(e);
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        rd_i     = rd;
        #1 stl = int'(stall_o);
        @(negedge clk_i);
        start_i  = 1'b0;
        funct3_i = 3'($urandom);
        op_a_i   = $urandom;
        op_b_i   = $urandom;
        rd_i     = ~rd;
        #1 lat = 1;
        while (!done_o && lat < 80) begin
            stl += int'(stall_o);
            @(negedge clk_i);
            #1 lat++;
        end
        e = sb.pop_front();
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_lat"}, lat, e.lat);
        chk({tag, "_stallcyc"}, stl, e.lat);
        chk({tag, "_stall_fix"}, 32'(stall_o), 32'd0);
        chk({tag, "_res"}, result_o, e.res);
        chk({tag, "_rd"}, 32'(rd_o), 32'(e.rd));
        @(negedge clk_i);
        #1;
        chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        chk({tag, "_hold"}, result_o, e.res);
    endtask

    initial begin
        int          dcnt;
        logic [31:0] last_res;
        rst_i    = 1'b1;
        start_i  = 1'b0;
        kill_i   = 1'b0;
        funct3_i = 3'd0;
        op_a_i   = 32'h0;
        op_b_i   = 32'h0;
        rd_i     = 5'd0;
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_res", result_o, 32'h0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        run_op("mul_7xm3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1,
               32'hFFFF_FFEB, 33);
        run_op("mulhu_ff", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
               32'hFFFF_FFFE, 33);
        run_op("mulh_ff", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
               32'h0, 33);
        run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4,
               32'hFFFF_FFFF, 33);
        run_op("mulhu_2p32", F3_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd5,
               32'h1, 33);
        run_op("mulh_min", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6,
               32'h4000_0000, 33);

        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,
               dv(32'h8000_0000), 1);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,
               32'h0, 1);
        run_op("divu_0", F3_DIVU, 32'd100, 32'd0, 5'd9,
               dv(32'hFFFF_FFFF), 1);
        run_op("remu_0", F3_REMU, 32'd100, 32'd0, 5'd10,
               dv(32'd100), 1);
        run_op("div_s0", F3_DIV, 32'hFFFF_FFFB, 32'd0, 5'd11,
               dv(32'hFFFF_FFFF), 1);
        run_op("rem_s0", F3_REM, 32'hFFFF_FFFB, 32'd0, 5'd12,
               dv(32'hFFFF_FFFB), 1);
        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd13,
               dv(32'hFFFF_FFFD), dl(33));
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd14,
               dv(32'hFFFF_FFFF), dl(33));
        run_op("divu_1000", F3_DIVU, 32'd1000, 32'd7, 5'd15,
               dv(32'd142), dl(33));
        run_op("remu_1000", F3_REMU, 32'd1000, 32'd7, 5'd16,
               dv(32'd6), dl(33));
        run_op("mul_pre", F3_MUL, 32'd6, 32'd7, 5'd17, 32'd42, 33);

        // kill on the 10th CALC cycle
        last_res = result_o;
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = F3_MUL;
        op_a_i   = 32'd9;
        op_b_i   = 32'd9;
        rd_i     = 5'd20;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        kill_i = 1'b1;
        #1 chk("kill_calc_stall_in", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        kill_i = 1'b0;
        #1 chk("kill_calc_stall", 32'(stall_o), 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk_i);
            dcnt += int'(done_o);
        end
        chk("kill_calc_nodone", dcnt, 0);
        chk("kill_calc_res", result_o, last_res);

        // kill beats start in IDLE
        @(negedge clk_i);
        start_i  = 1'b1;
        kill_i   = 1'b1;
        funct3_i = F3_MUL;
        op_a_i   = 32'd4;
        op_b_i   = 32'd4;
        #1 chk("kill_start_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        kill_i  = 1'b0;
        #1 chk("kill_start_idle", 32'(stall_o), 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk_i);
            dcnt += int'(done_o);
        end
        chk("kill_start_nodone", dcnt, 0);
        chk("kill_start_res", result_o, last_res);

        // asynchronous reset mid-CALC
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = F3_MUL;
        op_a_i   = 32'd11;
        op_b_i   = 32'd13;
        rd_i     = 5'd21;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_stall", 32'(stall_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_res", result_o, 32'h0);
        chk("arst_rd", 32'(rd_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk_i);
            dcnt += int'(done_o);
        end
        chk("arst_nodone", dcnt, 0);
        run_op("mul_3x5", F3_MUL, 32'd3, 32'd5, 5'd22, 32'd15, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have: clk_i  in  1  clock, rising-edge.
REQ-002 SHALL have: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: start_i  in  1  EX-stage instruction is an M-extension op (ALUOp R-type, funct7 0000001).
REQ-004 SHALL have: kill_i  in  1  EX flush; abandons the current op.
REQ-005 SHALL have: funct3_i  in  3  M-op select.
REQ-006 SHALL have: op_a_i, op_b_i  in  32 each  forwarded rs1 and rs2 operands.
REQ-007 SHALL have: rd_i  in  5  destination register.
REQ-008 SHALL have: stall_o  out  1  freeze PC, IF_ID and ID_EX.
REQ-009 SHALL have: done_o  out  1  result valid this cycle.
REQ-010 SHALL have: result_o  out  32  M-op result.
REQ-011 SHALL have: rd_o  out  5  destination register of result_o.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and FIX, with transitions only on the rising edge of clk_i.
REQ-013 SHALL, in IDLE with start_i=1 and kill_i=0, latch funct3, operand magnitudes/signs and rd_i, then go to CALC; or, for a special-case divide, go directly to FIX.
REQ-014 SHALL run CALC for exactly 32 cycles: radix-2 shift-add for MUL* (64-bit product), restoring shift-subtract for DIV*/REM*, 6-bit counter 0..31, then go to FIX.
REQ-015 SHALL, in FIX, apply sign correction and register result_o, drive done_o=1 (Moore, one cycle), and return to IDLE.
REQ-016 SHALL give a latency of 33 cycles for normal ops (start edge to done cycle) and 1 cycle for special cases.
REQ-017 SHALL drive stall_o = (IDLE & start_i & ~kill_i) | CALC; stall_o SHALL be 0 in FIX so EX_MEM captures result_o.
REQ-018 SHALL compute funct3 000 MUL as the low 32 bits of the product.
REQ-019 SHALL compute the high 32 bits for 001 MULH (s*s), 010 MULHSU (s*u) and 011 MULHU (u*u).
REQ-020 SHALL compute 100 DIV, 101 DIVU, 110 REM and 111 REMU with the quotient truncated toward zero and the remainder taking the dividend's sign.
REQ-021 SHALL handle divide by zero as a special case: quotient 0xFFFFFFFF, remainder = op_a_i.
REQ-022 SHALL handle signed overflow (0x80000000 / 0xFFFFFFFF) as a special case: DIV 0x80000000, REM 0.
REQ-023 SHALL ignore start_i in CALC and FIX.
REQ-024 SHALL, on kill_i=1 in any state, go to IDLE at the next edge with no done_o; kill_i SHALL win over a simultaneous start_i.
REQ-025 SHALL hold result_o and rd_o at their last values outside FIX.

Reset
REQ-026 SHALL, on rst_i, immediately force: state IDLE, counter 0, done_o 0, result_o 0, rd_o 0, internal accumulators 0.
REQ-027 SHALL let rst_i abort an in-flight op with no done_o; stall_o SHALL follow REQ-017 from the reset state.

Configuration
REQ-028 SHALL, with MULDIV_DIV_EN defined, implement all eight ops.
REQ-029 SHALL, without MULDIV_DIV_EN, omit the divider datapath: funct3[2]=1 ops go IDLE->FIX and return result_o 0 with 1-cycle latency; MUL* behaviour is unchanged.

Structure
REQ-030 SHALL take the following from shared package muldiv_pkg: funct3 op constants, FSM state enum, and the iteration count constant (32).
REQ-031 SHALL be a single module; no sub-module.

Verification
REQ-032 SHALL cover: MUL 7 x 0xFFFFFFFD -> result_o 0xFFFFFFEB, done_o 33 cycles after start, stall_o high for 33 cycles.
REQ-033 SHALL cover: MULHU and MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE and 0x00000000 respectively; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-034 SHALL cover: DIV/REM 0x80000000 by 0xFFFFFFFF -> 0x80000000 / 0, done_o after 1 cycle.
REQ-035 SHALL cover: DIVU/REMU 100 by 0 -> 0xFFFFFFFF / 100; DIV/REM -7 by 2 -> 0xFFFFFFFD / 0xFFFFFFFF.
REQ-036 SHALL cover: kill_i on CALC cycle 10 -> IDLE next edge, no done_o; kill_i with start_i in IDLE -> stall_o 0, no op.
REQ-037 SHALL cover: rst_i asserted mid-CALC -> all outputs 0 asynchronously; a new MUL 3 x 5 after release -> 15 after 33 cycles.
